// File: rtl/axi2per_pkg.sv
// axi2per_pkg: shared FSM encoding and index-width helper for the axi2per bridge
package axi2per_pkg;
    typedef enum logic {IDLE, LOCKED} r_arb_state_e;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/axi2per_rr_prio.sv
// axi2per_rr_prio: round-robin priority encoder, first request at or after ptr wins
module axi2per_rr_prio
    import axi2per_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);
    always_comb begin
        found_o = |req_i;
        idx_o   = '0;
        // descending scan so the smallest offset from ptr is assigned last
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % N]) idx_o = IW'((int'(ptr_i) + i) % N);
        end
    end
endmodule

// File: rtl/axi2per_r_arbiter.sv
// axi2per_r_arbiter: burst-locked round-robin sharing of one AXI R channel
// between N_SLAVES sources, zero-latency forwarding.
module axi2per_r_arbiter
    import axi2per_pkg::*;
#(
    parameter int N_SLAVES   = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [N_SLAVES-1:0]              slave_valid_i,
    input  logic [N_SLAVES*DATA_WIDTH-1:0]   slave_data_i,
    input  logic [N_SLAVES*2-1:0]            slave_resp_i,
    input  logic [N_SLAVES*USER_WIDTH-1:0]   slave_user_i,
    input  logic [N_SLAVES*ID_WIDTH-1:0]     slave_id_i,
    input  logic [N_SLAVES-1:0]              slave_last_i,
    output logic [N_SLAVES-1:0]              slave_ready_o,
    output logic                             master_valid_o,
    output logic [DATA_WIDTH-1:0]            master_data_o,
    output logic [1:0]                       master_resp_o,
    output logic [USER_WIDTH-1:0]            master_user_o,
    output logic [ID_WIDTH-1:0]              master_id_o,
    output logic                             master_last_o,
    input  logic                             master_ready_i,
    output logic [N_SLAVES-1:0]              grant_o,
    output logic                             locked_o,
    output logic [CNT_WIDTH-1:0]             beat_cnt_o
);
    localparam int IW = idx_w(N_SLAVES);

    r_arb_state_e   state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d, owner_q, owner_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [IW-1:0]       ptr_eff, win_idx, sel, sel_nxt;
    logic                found, locked, pres, owns, hs;
    logic [N_SLAVES-1:0] sel_oh;

    assign ptr_eff = rst_i ? '0 : ptr_q;

    axi2per_rr_prio #(.N(N_SLAVES), .IW(IW)) u_prio (
        .req_i   (slave_valid_i),
        .ptr_i   (ptr_eff),
        .found_o (found),
        .idx_o   (win_idx)
    );

    // reset masks the registered state so outputs look like IDLE with ptr=0
    always_comb begin
        locked         = (state_q == LOCKED) && !rst_i;
        sel            = locked ? owner_q : win_idx;
        sel_nxt        = (sel == IW'(N_SLAVES - 1)) ? '0 : sel + 1'b1;
        sel_oh         = {{(N_SLAVES-1){1'b0}}, 1'b1} << sel;
        owns           = locked || found;
        pres           = locked ? slave_valid_i[sel] : found;
        hs             = pres && master_ready_i;
        master_valid_o = pres;
        master_data_o  = pres ? slave_data_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
        master_resp_o  = pres ? slave_resp_i[int'(sel)*2 +: 2] : '0;
        master_user_o  = pres ? slave_user_i[int'(sel)*USER_WIDTH +: USER_WIDTH] : '0;
        master_id_o    = pres ? slave_id_i[int'(sel)*ID_WIDTH +: ID_WIDTH] : '0;
        master_last_o  = pres && slave_last_i[sel];
        grant_o        = pres ? sel_oh : '0;
        slave_ready_o  = (master_ready_i && owns) ? sel_oh : '0;
        locked_o       = locked;
        beat_cnt_o     = rst_i ? '0 : cnt_q;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (!locked) begin
            if (hs && master_last_o) begin
                ptr_d = sel_nxt;
            end else if (found) begin
                state_d = LOCKED;
                owner_d = win_idx;
                cnt_d   = hs ? CNT_WIDTH'(1) : '0;
            end
        end else if (hs) begin
            cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
            if (master_last_o) begin
                state_d = IDLE;
                ptr_d   = sel_nxt;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
